// File: rtl/product_bcd_converter.sv
// product_bcd_converter: sequential double-dabble of a signed-magnitude product into packed BCD.
// Optional leading-zero blanking mask enabled by defining LEADING_ZERO_BLANK_EN.
module product_bcd_converter #(
  parameter int WIDTH  = 15,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      product,
  input  logic                  sign,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [DIGITS-1:0]     digit_blank
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_digits_too_few
    $error("DIGITS too small to hold 2**WIDTH-1");
  end
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic [BW-1:0] scr_q, adj, scr_n;
  logic [CW-1:0] cnt_q;
  logic neg_q, accept, last;
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scr_q[4*i+:4] >= 4'd5 ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
  end
  assign scr_n   = {adj[BW-2:0], shift_q[WIDTH-1]};
  assign shift_n = {shift_q[WIDTH-2:0], 1'b0};
  assign accept  = start && state != CONV;
  assign last    = state == CONV && cnt_q == CW'(WIDTH - 1);
  assign busy    = state == CONV;
  assign done    = state == DONE;
  always_comb begin
    state_n = accept ? CONV : state == CONV ? (last ? DONE : CONV) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      bcd     <= '0;
      neg     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        shift_q <= product;
        scr_q   <= '0;
        cnt_q   <= '0;
        neg_q   <= sign && |product;
      end else if (state == CONV) begin
        shift_q <= shift_n;
        scr_q   <= scr_n;
        cnt_q   <= cnt_q + 1'b1;
      end
      if (last) begin
        bcd <= scr_n;
        neg <= neg_q;
      end
    end
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_n;
  logic z;
  // digit i blanks when it and every higher digit are zero; units digit never blanks
  always_comb begin
    blank_n = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z && scr_n[4*i+:4] == 4'd0;
      blank_n[i] = z;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) digit_blank <= '0;
    else if (last) digit_blank <= blank_n;
  end
`else
  assign digit_blank = '0;
`endif
endmodule

// File: tb/tb_product_bcd_converter.sv
// tb_product_bcd_converter: randomized and directed checks against an arithmetic BCD model.
module tb_product_bcd_converter;
  localparam int WIDTH = 15;
  localparam int DIGITS = 5;
  logic clk = 0, rst_n = 0, start = 0, sign = 0;
  logic [WIDTH-1:0] product = '0;
  logic busy, done, neg;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0] digit_blank;
  int n_chk = 0, n_pass = 0;
  logic [31:0] exp_bcd = 0;
  product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .product(product), .sign(sign),
    .busy(busy), .done(done), .bcd(bcd), .neg(neg), .digit_blank(digit_blank)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [31:0] ref_bcd(input int p);
    logic [31:0] r = 0;
    int d = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'((p / d) % 10);
      d *= 10;
    end
    return r;
  endfunction
  function automatic logic [31:0] ref_blank(input int p);
    logic [31:0] r = 0;
`ifdef LEADING_ZERO_BLANK_EN
    int d = 10;
    for (int i = 1; i < DIGITS; i++) begin
      r[i] = p < d;
      d *= 10;
    end
`endif
    return r;
  endfunction
  task automatic run(input int p, input bit s, input bit poke);
    int cyc, nb;
    bit got;
    @(posedge clk); #1;
    start = 1; product = WIDTH'(p); sign = s;
    @(posedge clk); #1;
    start = 0; product = WIDTH'($urandom); sign = 1'($urandom);
    chk("busy_after_start", busy, 1);
    chk("bcd_held_in_conv", bcd, exp_bcd);
    cyc = 0; nb = 1; got = 0;
    while (!got && cyc < 40) begin
      if (poke && (cyc == 2 || cyc == 7)) begin start = 1; product = 99; end
      @(posedge clk); #1;
      start = 0; cyc++;
      if (done) got = 1;
      else if (busy) nb++;
    end
    chk("done_seen", 32'(got), 1);
    chk("latency", cyc, WIDTH);
    chk("busy_cycles", nb, WIDTH);
    chk("busy_at_done", busy, 0);
    exp_bcd = ref_bcd(p);
    chk("bcd", bcd, exp_bcd);
    chk("neg", neg, 32'(s && p != 0));
    chk("blank", digit_blank, ref_blank(p));
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("bcd_hold", bcd, exp_bcd);
  endtask
  task automatic no_done(input string tag, input int n);
    int seen = 0;
    repeat (n) begin @(posedge clk); #1; if (done) seen++; end
    chk(tag, seen, 0);
  endtask
  initial begin
    int c1, c2, gap;
    bit held;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_neg", neg, 0);
    chk("rst_blank", digit_blank, 0);
    rst_n = 1;
    run(0, 1, 0);
    run(32767, 0, 0);
    run(12345, 1, 1);
    no_done("no_extra_done", 20);
    run(42, 0, 0);
    run(0, 0, 0);
    @(posedge clk); #1;
    start = 1; product = 500; sign = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_done", done, 0);
    exp_bcd = 0;
    no_done("abort_no_done", 20);
    run(7, 0, 0);
    @(posedge clk); #1;
    start = 1; product = 1; sign = 0;
    @(posedge clk); #1;
    product = 2;
    c1 = 0; c2 = 0; held = 1;
    for (int t = 1; t <= 40 && c2 == 0; t++) begin
      @(posedge clk); #1;
      if (done && c1 == 0) begin c1 = t; chk("b2b_first", bcd, ref_bcd(1)); end
      else if (done) begin c2 = t; start = 0; chk("b2b_second", bcd, ref_bcd(2)); end
      else if (c1 != 0 && bcd !== ref_bcd(1)) held = 0;
    end
    start = 0;
    chk("b2b_first_lat", c1, WIDTH);
    chk("b2b_spacing", c2 - c1, WIDTH + 1);
    chk("b2b_held", 32'(held), 1);
    exp_bcd = ref_bcd(2);
    no_done("b2b_stop", 20);
    for (int k = 0; k < 25; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      run(k < 3 ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 32767)), 1'($urandom), 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
